// File: rtl/usb_evt_queue_pkg.sv
// Shared defaults, event field layout and helpers for the USB event queue.
// Optional feature macro (used by usb_evt_queue): USB_EVT_DROP_CNT_EN.
package usb_evt_queue_pkg;

  localparam int DEF_DW    = 12;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CW    = 4;

  // Event payload layout as produced by the transaction controller
  localparam int EVT_EP_LSB = 0;
  localparam int EVT_EP_W   = 4;
  localparam int EVT_DIR    = 4;
  localparam int EVT_SETUP  = 5;

  // A zero threshold would make the IRQ fire with nothing pending, so it means 1
  function automatic logic [15:0] thresh_eff(input logic [15:0] thresh);
    return (thresh == 16'd0) ? 16'd1 : thresh;
  endfunction

endpackage

// File: rtl/usb_evt_fifo.sv
// Pointer-based synchronous show-ahead FIFO with flush, full/empty and level.
module usb_evt_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic [LW-1:0] level_nxt
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          pop_ok, push_ok;

  // Explicit wrap keeps the pointers correct for DEPTH=1 as well
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign pop_ok    = pop & ~empty & ~flush;
  assign push_ok   = push & (~full | pop_ok) & ~flush;
  assign rdata     = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign level_nxt = level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/usb_evt_queue.sv
// USB event queue: FIFO or count-only event capture, overflow flag, IRQ coalescing.
// Optional macro USB_EVT_DROP_CNT_EN adds a saturating drop_cnt output.
module usb_evt_queue
  import usb_evt_queue_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] evt_data,
  input  logic          evt_stb,
  input  logic          rd_ack,
  input  logic          flush,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [CW-1:0] rd_cnt,
  output logic          rd_ovf,
  input  logic          cfg_irq_ena,
  input  logic [CW-1:0] cfg_irq_thresh,
  input  logic [15:0]   cfg_irq_timeout,
  output logic          irq
`ifdef USB_EVT_DROP_CNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  logic [CW-1:0] cnt_cur, cnt_nxt;
  logic          drop;

  generate
    if (DEPTH == 0) begin : g_count
      logic [CW-1:0] cnt_q, cnt_d;
      logic          sat;

      assign sat = (cnt_q == {CW{1'b1}});

      always_comb begin
        cnt_d = cnt_q;
        if (flush)                cnt_d = '0;
        else if (rd_ack)          cnt_d = CW'(evt_stb);
        else if (evt_stb && !sat) cnt_d = cnt_q + CW'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      // An ack reloads the counter, so a strobe alongside it is never lost
      assign drop     = evt_stb & sat & ~rd_ack & ~flush;
      assign cnt_cur  = cnt_q;
      assign cnt_nxt  = cnt_d;
      assign rd_data  = '0;
      assign rd_valid = (cnt_q != '0);
    end else begin : g_fifo
      localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
      localparam int LW = $clog2(DEPTH + 1);

      logic          full, empty;
      logic [LW-1:0] level, level_nxt;
      logic [DW-1:0] head;

      usb_evt_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW),
        .LW    (LW)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (evt_stb),
        .pop       (rd_ack),
        .wdata     (evt_data),
        .rdata     (head),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .level_nxt (level_nxt)
      );

      assign drop     = evt_stb & full & ~rd_ack & ~flush;
      assign cnt_cur  = CW'(level);
      assign cnt_nxt  = CW'(level_nxt);
      assign rd_data  = empty ? '0 : head;
      assign rd_valid = ~empty;
    end
  endgenerate

  logic        ovf_q, ovf_d;
  logic [15:0] timer_q, timer_d;
  logic        irq_q, irq_d;
  logic [15:0] thr;
  logic        irq_cond;

  assign thr      = thresh_eff(16'(cfg_irq_thresh));
  assign irq_cond = (16'(cnt_cur) >= thr) |
                    ((cfg_irq_timeout != 16'd0) & (cnt_cur != '0) & (timer_q == 16'd0));

  always_comb begin
    ovf_d   = ovf_q;
    timer_d = timer_q;
    irq_d   = cfg_irq_ena & irq_cond;
    if (flush)       ovf_d = 1'b0;
    else if (drop)   ovf_d = 1'b1;
    else if (rd_ack) ovf_d = 1'b0;
    // Load only on the empty-to-pending edge; later cfg changes never reload
    if (flush || cnt_nxt == '0)  timer_d = 16'd0;
    else if (cnt_cur == '0)      timer_d = cfg_irq_timeout;
    else if (timer_q != 16'd0)   timer_d = timer_q - 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q   <= 1'b0;
      timer_q <= 16'd0;
      irq_q   <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      timer_q <= timer_d;
      irq_q   <= irq_d;
    end
  end

  assign rd_cnt = cnt_cur;
  assign rd_ovf = ovf_q;
  assign irq    = irq_q;

`ifdef USB_EVT_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush)                            drop_cnt_d = 8'd0;
    else if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_usb_evt_queue.sv
// Self-checking bench: a DEPTH=4 FIFO instance and a DEPTH=0 count-only instance
// driven by the same stimulus and compared against a queue/arithmetic model.
module tb_usb_evt_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] evt_data;
  logic        evt_stb, rd_ack, flush;
  logic        cfg_irq_ena;
  logic [3:0]  cfg_irq_thresh;
  logic [15:0] cfg_irq_timeout;

  logic [11:0] a_data, b_data;
  logic        a_valid, b_valid, a_ovf, b_ovf, a_irq, b_irq;
  logic [3:0]  a_cnt, b_cnt;
`ifdef USB_EVT_DROP_CNT_EN
  logic [7:0]  a_drop, b_drop;
`endif

  always #5 clk = ~clk;

  usb_evt_queue #(.DW(12), .DEPTH(4), .CW(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .evt_data(evt_data), .evt_stb(evt_stb),
    .rd_ack(rd_ack), .flush(flush), .rd_data(a_data), .rd_valid(a_valid),
    .rd_cnt(a_cnt), .rd_ovf(a_ovf), .cfg_irq_ena(cfg_irq_ena),
    .cfg_irq_thresh(cfg_irq_thresh), .cfg_irq_timeout(cfg_irq_timeout), .irq(a_irq)
`ifdef USB_EVT_DROP_CNT_EN
    , .drop_cnt(a_drop)
`endif
  );

  usb_evt_queue #(.DW(12), .DEPTH(0), .CW(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .evt_data(evt_data), .evt_stb(evt_stb),
    .rd_ack(rd_ack), .flush(flush), .rd_data(b_data), .rd_valid(b_valid),
    .rd_cnt(b_cnt), .rd_ovf(b_ovf), .cfg_irq_ena(cfg_irq_ena),
    .cfg_irq_thresh(cfg_irq_thresh), .cfg_irq_timeout(cfg_irq_timeout), .irq(b_irq)
`ifdef USB_EVT_DROP_CNT_EN
    , .drop_cnt(b_drop)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  // Reference model state
  int qa[$];
  bit ovf_a, irq_a;
  int dcnt_a, tl_a, age_a;
  int cnt_b, dcnt_b, tl_b, age_b;
  bit ovf_b, irq_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, n_cyc);
    end
  endtask

  function automatic int tmr(input int tl, input int age);
    return (tl > age) ? tl - age : 0;
  endfunction

  task automatic model_reset();
    qa.delete();
    ovf_a = 0; irq_a = 0; dcnt_a = 0; tl_a = 0; age_a = 0;
    cnt_b = 0; ovf_b = 0; irq_b = 0; dcnt_b = 0; tl_b = 0; age_b = 0;
  endtask

  task automatic model_edge();
    int thr, old_a, old_b, tout;
    bit drop;
    thr   = (cfg_irq_thresh == 0) ? 1 : int'(cfg_irq_thresh);
    tout  = int'(cfg_irq_timeout);
    old_a = qa.size();
    old_b = cnt_b;
    irq_a = cfg_irq_ena && (old_a >= thr || (tout != 0 && old_a != 0 && tmr(tl_a, age_a) == 0));
    irq_b = cfg_irq_ena && (old_b >= thr || (tout != 0 && old_b != 0 && tmr(tl_b, age_b) == 0));
    // FIFO instance
    if (flush) begin
      qa.delete(); ovf_a = 0; dcnt_a = 0;
    end else begin
      drop = 0;
      if (rd_ack && qa.size() > 0) void'(qa.pop_front());
      if (evt_stb) begin
        if (qa.size() < 4) qa.push_back(int'(evt_data));
        else drop = 1;
      end
      if (drop) begin
        ovf_a = 1;
        if (dcnt_a < 255) dcnt_a++;
      end else if (rd_ack) ovf_a = 0;
    end
    if (qa.size() == 0) age_a = 0;
    else if (old_a == 0) begin tl_a = tout; age_a = 0; end
    else age_a++;
    // Count-only instance
    if (flush) begin
      cnt_b = 0; ovf_b = 0; dcnt_b = 0;
    end else if (rd_ack) begin
      cnt_b = evt_stb ? 1 : 0; ovf_b = 0;
    end else if (evt_stb) begin
      if (cnt_b == 15) begin
        ovf_b = 1;
        if (dcnt_b < 255) dcnt_b++;
      end else cnt_b++;
    end
    if (cnt_b == 0) age_b = 0;
    else if (old_b == 0) begin tl_b = tout; age_b = 0; end
    else age_b++;
  endtask

  task automatic check_all();
    chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
    chk("a_data",  32'(a_data),  (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
    chk("a_cnt",   32'(a_cnt),   32'(qa.size()));
    chk("a_ovf",   32'(a_ovf),   32'(ovf_a));
    chk("a_irq",   32'(a_irq),   32'(irq_a));
    chk("b_valid", 32'(b_valid), 32'(cnt_b != 0));
    chk("b_data",  32'(b_data),  32'd0);
    chk("b_cnt",   32'(b_cnt),   32'(cnt_b));
    chk("b_ovf",   32'(b_ovf),   32'(ovf_b));
    chk("b_irq",   32'(b_irq),   32'(irq_b));
`ifdef USB_EVT_DROP_CNT_EN
    chk("a_drop",  32'(a_drop),  32'(dcnt_a));
    chk("b_drop",  32'(b_drop),  32'(dcnt_b));
`endif
  endtask

  // One clock cycle with the given inputs; outputs checked on the falling edge
  task automatic cyc(input bit s, input int d, input bit a, input bit f);
    evt_stb  = s;
    evt_data = 12'(d);
    rd_ack   = a;
    flush    = f;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    n_cyc++;
    $display("cyc=%0d stb=%0d data=%03h ack=%0d flush=%0d | a: v=%0d d=%03h c=%0d o=%0d i=%0d | b: c=%0d o=%0d i=%0d",
             n_cyc, s, 12'(d), a, f, a_valid, a_data, a_cnt, a_ovf, a_irq, b_cnt, b_ovf, b_irq);
    check_all();
    evt_stb = 0; rd_ack = 0; flush = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    int lat;
    bit seen;
    rst_n = 0; evt_stb = 0; rd_ack = 0; flush = 0; evt_data = '0;
    cfg_irq_ena = 0; cfg_irq_thresh = 4'd15; cfg_irq_timeout = 16'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    check_all();
    chk("reset_cnt", 32'(a_cnt), 32'd0);

    // Three pushes, show-ahead head, three pops
    cyc(1, 'h101, 0, 0);
    chk("dir_head_first", 32'(a_data), 32'h101);
    cyc(1, 'h102, 0, 0);
    cyc(1, 'h103, 0, 0);
    chk("dir_cnt3", 32'(a_cnt), 32'd3);
    cyc(0, 0, 1, 0);
    chk("dir_pop1", 32'(a_data), 32'h102);
    cyc(0, 0, 1, 0);
    chk("dir_pop2", 32'(a_data), 32'h103);
    cyc(0, 0, 1, 0);
    chk("dir_empty", 32'(a_valid), 32'd0);

    // Overflow on full, cleared by ack
    for (int i = 0; i < 4; i++) cyc(1, 'h201 + i, 0, 0);
    cyc(1, 'h0AA, 0, 0);
    chk("dir_ovf_set", 32'(a_ovf), 32'd1);
    chk("dir_ovf_cnt", 32'(a_cnt), 32'd4);
    cyc(0, 0, 1, 0);
    chk("dir_ovf_clr", 32'(a_ovf), 32'd0);
    chk("dir_ack_cnt", 32'(a_cnt), 32'd3);
`ifdef USB_EVT_DROP_CNT_EN
    chk("dir_dropcnt_kept", 32'(a_drop), 32'd1);
`endif

    // Full with simultaneous push and pop
    cyc(1, 'h205, 0, 0);
    cyc(1, 'h055, 1, 0);
    chk("dir_fullpp_cnt", 32'(a_cnt), 32'd4);
    chk("dir_fullpp_ovf", 32'(a_ovf), 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("dir_last_055", 32'(a_data), 32'h055);
    cyc(0, 0, 1, 0);

    // Threshold IRQ
    cyc(0, 0, 0, 1);
    cfg_irq_ena = 1; cfg_irq_thresh = 4'd3; cfg_irq_timeout = 16'd0;
    cyc(1, 'h301, 0, 0);
    cyc(1, 'h302, 0, 0);
    idle(1);
    chk("dir_thr_below", 32'(a_irq), 32'd0);
    cyc(1, 'h303, 0, 0);
    idle(1);
    chk("dir_thr_hit", 32'(a_irq), 32'd1);
    cyc(0, 0, 1, 0);
    idle(1);
    chk("dir_thr_drop", 32'(a_irq), 32'd0);

    // Timeout IRQ, then masked by ena=0
    cyc(0, 0, 0, 1);
    cfg_irq_thresh = 4'd8; cfg_irq_timeout = 16'd10;
    cyc(1, 'h401, 0, 0);
    lat = 1;
    while (!a_irq && lat < 30) begin
      idle(1);
      lat++;
    end
    chk("dir_tmo_latency", 32'(lat >= 11 && lat <= 12), 32'd1);
    cyc(0, 0, 1, 0);
    idle(1);
    chk("dir_tmo_clear", 32'(a_irq), 32'd0);
    cfg_irq_ena = 0;
    cyc(1, 'h402, 0, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      seen |= a_irq;
    end
    chk("dir_tmo_masked", 32'(seen), 32'd0);

    // Count-only saturation, flush with concurrent strobe
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 17; i++) cyc(1, i, 0, 0);
    chk("dir_cnt_sat", 32'(b_cnt), 32'd15);
    chk("dir_cnt_ovf", 32'(b_ovf), 32'd1);
    cyc(1, 'h7FF, 0, 1);
    chk("dir_flush_cnt", 32'(b_cnt), 32'd0);
    chk("dir_flush_ovf", 32'(b_ovf), 32'd0);

    // Randomized traffic with periodic cfg changes
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        cfg_irq_ena     = 1'($urandom_range(0, 3) != 0);
        cfg_irq_thresh  = 4'($urandom_range(0, 7));
        cfg_irq_timeout = 16'($urandom_range(0, 15));
      end
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cyc(1, 'h500 + i, 0, 0);
    evt_stb = 1; evt_data = 12'h5AA;
    #2 rst_n = 0;
    #1;
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_data",  32'(a_data),  32'd0);
    chk("rst_a_cnt",   32'(a_cnt),   32'd0);
    chk("rst_a_ovf",   32'(a_ovf),   32'd0);
    chk("rst_a_irq",   32'(a_irq),   32'd0);
    chk("rst_b_cnt",   32'(b_cnt),   32'd0);
    chk("rst_b_ovf",   32'(b_ovf),   32'd0);
    chk("rst_b_irq",   32'(b_irq),   32'd0);
    model_reset();
    evt_stb = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    check_all();
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
